// File: rtl/nios2_cpu_div_cell.sv
// nios2_cpu_div_cell: iterative 32/32 restoring divider for DIV/DIVU.
// Operands are latched on an accepted start. The cell is busy through the
// done cycle, and the quotient and remainder are held until they are replaced.
// Optional build macro NIOS2_DIV_FAST_PATH_EN: when the divisor is zero or
// |dividend| < |divisor|, the cell skips the iteration phase. Results are the
// same either way; only the latency changes.
module nios2_cpu_div_cell #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] E_src1,
  input  logic [WIDTH-1:0] E_src2,
  input  logic             E_div_start,
  input  logic             E_div_signed,
  output logic             M_div_busy,
  output logic             M_div_done,
  output logic [WIDTH-1:0] M_div_quot,
  output logic [WIDTH-1:0] M_div_rem,
  output logic             M_div_by_zero
);

  // The DONE state is the visible output cycle that follows FIX. It keeps the
  // FSM out of IDLE while done is high, so a start in that cycle is dropped.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  logic [2:0]       state;
  logic [WIDTH-1:0] a_reg;      // dividend exactly as given
  logic [WIDTH-1:0] b_reg;      // divisor exactly as given
  logic             sgn_reg;
  logic [WIDTH-1:0] dvs_reg;    // divisor magnitude
  logic [WIDTH-1:0] rem_reg;    // partial remainder
  logic [WIDTH-1:0] quot_reg;   // dividend bits shift out as quotient bits shift in
  logic [CNT_W-1:0] cnt_reg;
  logic             q_neg;
  logic             r_neg;
  logic             zero_reg;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_ext;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // Magnitudes use two's-complement absolute values, so 0x80000000 maps to itself.
  assign a_mag = (sgn_reg && a_reg[WIDTH-1]) ? (~a_reg + 1'b1) : a_reg;
  assign b_mag = (sgn_reg && b_reg[WIDTH-1]) ? (~b_reg + 1'b1) : b_reg;

  // Restoring step. The shifted remainder is 33 bits wide. When its top bit is
  // set it always exceeds the divisor. Otherwise bit 32 of diff is the borrow.
  assign rem_ext = {rem_reg, quot_reg[WIDTH-1]};
  assign diff    = rem_ext - {1'b0, dvs_reg};
  assign ge      = rem_reg[WIDTH-1] | ~diff[WIDTH];

  assign quot_fix = q_neg ? (~quot_reg + 1'b1) : quot_reg;
  assign rem_fix  = r_neg ? (~rem_reg + 1'b1) : rem_reg;

  assign M_div_busy = (state != S_IDLE);
  assign M_div_done = (state == S_DONE);

  // Sequence the FSM, the datapath and the held result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      sgn_reg       <= 1'b0;
      dvs_reg       <= '0;
      rem_reg       <= '0;
      quot_reg      <= '0;
      cnt_reg       <= '0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      zero_reg      <= 1'b0;
      M_div_quot    <= '0;
      M_div_rem     <= '0;
      M_div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (E_div_start) begin
            a_reg   <= E_src1;
            b_reg   <= E_src2;
            sgn_reg <= E_div_signed;
            state   <= S_PREP;
          end
        end
        S_PREP: begin
          q_neg    <= sgn_reg & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
          r_neg    <= sgn_reg & a_reg[WIDTH-1];
          dvs_reg  <= b_mag;
          zero_reg <= (b_reg == '0);
          rem_reg  <= '0;
          quot_reg <= a_mag;
          cnt_reg  <= CNT_LOAD;
          state    <= S_ITER;
`ifdef NIOS2_DIV_FAST_PATH_EN
          // Trivial cases: quotient 0 and remainder |dividend|. FIX restores the sign.
          if ((b_reg == '0) || (a_mag < b_mag)) begin
            rem_reg  <= a_mag;
            quot_reg <= '0;
            state    <= S_FIX;
          end
`endif
        end
        S_ITER: begin
          rem_reg  <= ge ? diff[WIDTH-1:0] : rem_ext[WIDTH-1:0];
          quot_reg <= {quot_reg[WIDTH-2:0], ge};
          cnt_reg  <= cnt_reg - 1'b1;
          if (cnt_reg == CNT_LAST) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          // Divide-by-zero returns all-ones and the raw dividend, with no sign fix.
          if (zero_reg) begin
            M_div_quot <= '1;
            M_div_rem  <= a_reg;
          end else begin
            M_div_quot <= quot_fix;
            M_div_rem  <= rem_fix;
          end
          M_div_by_zero <= zero_reg;
          state         <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_cpu_div_cell.sv
// Directed self-checking bench for nios2_cpu_div_cell.
// Expected latencies follow the NIOS2_DIV_FAST_PATH_EN build macro.
module tb_nios2_cpu_div_cell;

  logic        clk;
  logic        reset_n;
  logic [31:0] E_src1;
  logic [31:0] E_src2;
  logic        E_div_start;
  logic        E_div_signed;
  logic        M_div_busy;
  logic        M_div_done;
  logic [31:0] M_div_quot;
  logic [31:0] M_div_rem;
  logic        M_div_by_zero;

  int checks = 0;
  int errors = 0;

`ifdef NIOS2_DIV_FAST_PATH_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  nios2_cpu_div_cell dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .E_src1       (E_src1),
    .E_src2       (E_src2),
    .E_div_start  (E_div_start),
    .E_div_signed (E_div_signed),
    .M_div_busy   (M_div_busy),
    .M_div_done   (M_div_done),
    .M_div_quot   (M_div_quot),
    .M_div_rem    (M_div_rem),
    .M_div_by_zero(M_div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each task is entered and left 1 time unit after a rising edge.
  task automatic test_reset();
    reset_n = 1'b0;
    E_div_start = 1'b0; E_div_signed = 1'b0; E_src1 = '0; E_src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (M_div_busy !== 1'b0 || M_div_done !== 1'b0 || M_div_quot !== 32'h0 ||
        M_div_rem !== 32'h0 || M_div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b quot=%h rem=%h dz=%b required 0/0/0/0/0",
               M_div_busy, M_div_done, M_div_quot, M_div_rem, M_div_by_zero);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: busy=%b quot=%h rem=%h", M_div_busy, M_div_quot, M_div_rem);
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input bit fast, input logic [31:0] eq,
                        input logic [31:0] er, input logic ez);
    int c;
    int done_c;
    int busy_cnt;
    int lat;
    lat = (FP && fast) ? 3 : 35;
    E_src1 = a; E_src2 = b; E_div_signed = sgn; E_div_start = 1'b1;
    @(posedge clk); #1;
    E_div_start = 1'b0;
    c = 1; done_c = 0; busy_cnt = 0;
    while (c <= 60 && done_c == 0) begin
      if (M_div_busy === 1'b1) busy_cnt++;
      if (M_div_done === 1'b1) done_c = c;
      else begin
        @(posedge clk); #1;
        c++;
      end
    end
    checks++;
    if (done_c != lat) begin
      errors++;
      $display("FAIL %s_latency done at N+%0d required N+%0d", name, done_c, lat);
    end
    checks++;
    if (busy_cnt != lat) begin
      errors++;
      $display("FAIL %s_busy busy cycles %0d required %0d", name, busy_cnt, lat);
    end
    checks++;
    if (M_div_quot !== eq || M_div_rem !== er || M_div_by_zero !== ez) begin
      errors++;
      $display("FAIL %s_result quot=%h rem=%h dz=%b required quot=%h rem=%h dz=%b",
               name, M_div_quot, M_div_rem, M_div_by_zero, eq, er, ez);
    end
    @(posedge clk); #1;
    checks++;
    if (M_div_done !== 1'b0 || M_div_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_done done=%b busy=%b required 0/0", name, M_div_done, M_div_busy);
    end
    $display("%s: a=%h b=%h signed=%b -> quot=%h rem=%h dz=%b done@N+%0d",
             name, a, b, sgn, M_div_quot, M_div_rem, M_div_by_zero, done_c);
  endtask

  task automatic test_basic();
    run_op("divu_100_7", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 32'd2, 1'b0);
    run_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_overflow();
    run_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0);
    run_op("divu_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, 32'h8000_0000, 1'b0);
  endtask

  task automatic test_div_by_zero();
    run_op("divu_5_0", 32'd5, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run_op("div_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
  endtask

  task automatic test_back_to_back();
    int c;
    int done_c;
    E_src1 = 32'd20; E_src2 = 32'd3; E_div_signed = 1'b0; E_div_start = 1'b1;
    @(posedge clk); #1;
    E_div_start = 1'b0;
    c = 1; done_c = 0;
    while (c <= 60 && done_c == 0) begin
      if (M_div_done === 1'b1) begin
        done_c = c;
        E_src1 = 32'd1; E_src2 = 32'd1; E_div_start = 1'b1;   // start coincident with done
      end else begin
        if (c == 3 || c == 10 || c == 20) begin
          E_src1 = 32'd99; E_src2 = 32'd4; E_div_start = 1'b1;
        end else begin
          E_div_start = 1'b0;
        end
        @(posedge clk); #1;
        c++;
      end
    end
    checks++;
    if (done_c != 35) begin
      errors++;
      $display("FAIL b2b_latency done at N+%0d required N+35", done_c);
    end
    checks++;
    if (M_div_quot !== 32'd6 || M_div_rem !== 32'd2) begin
      errors++;
      $display("FAIL b2b_result quot=%h rem=%h required 00000006/00000002", M_div_quot, M_div_rem);
    end
    @(posedge clk); #1;
    E_div_start = 1'b0;
    checks++;
    if (M_div_busy !== 1'b0 || M_div_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_start_ignored busy=%b done=%b required 0/0", M_div_busy, M_div_done);
    end
    $display("b2b: 20/3 quot=%h rem=%h, starts during busy/done ignored", M_div_quot, M_div_rem);
    run_op("divu_ffffffff_10", 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0, 32'h0FFF_FFFF, 32'hF, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    bit saw_done;
    saw_done = 1'b0;
    E_src1 = 32'd1000; E_src2 = 32'd10; E_div_signed = 1'b0; E_div_start = 1'b1;
    @(posedge clk); #1;
    E_div_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (M_div_busy !== 1'b0 || M_div_done !== 1'b0 || M_div_quot !== 32'h0 ||
        M_div_rem !== 32'h0 || M_div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset busy=%b done=%b quot=%h rem=%h dz=%b required 0/0/0/0/0",
               M_div_busy, M_div_done, M_div_quot, M_div_rem, M_div_by_zero);
    end
    E_src1 = 32'd50; E_src2 = 32'd5; E_div_start = 1'b1;   // start while in reset
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (M_div_busy !== 1'b0) begin
      errors++;
      $display("FAIL start_in_reset busy=%b required 0", M_div_busy);
    end
    E_div_start = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (M_div_done === 1'b1 || M_div_busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abandoned_op activity seen=1 required 0");
    end
    $display("reset_mid_op: outputs cleared, no done pulse");
    run_op("divu_6_3", 32'd6, 32'd3, 1'b0, 1'b0, 32'd2, 32'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_div_by_zero();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
